ramp_shaper: RTL and testbench
==============================

Name: ramp_shaper

Overview:
- Transmit-side counterpart of the receive block averager.
- Accepts signed 16-bit amplitude samples from an upstream source through a valid/ready FIFO.
- Releases one sample per sample tick, derived from the NCO phase bit selected by sample_rate.
- Drives a linearly ramped amplitude toward each new sample so the modulator sees no step discontinuities.

Parameters:
- DEPTH, 16, FIFO depth in samples; power of 2, minimum 2.
- RAMP_LOG2, 6, ramp length is 2^RAMP_LOG2 clocks per transition.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- phase  input  32  current phase of the centre-frequency NCO.
- sample_rate  input  5  index of the phase bit that defines the sample tick.
- in_data  input  16  signed sample to enqueue.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  FIFO can accept; equals !full, combinational from the level register.
- shaped  output  16  signed shaped amplitude, registered.
- underflow  output  1  one-clock pulse: a tick occurred with the FIFO empty.
- fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async, rst_n=0):
  - shaped=0, underflow=0, fifo_level=0, FIFO emptied and contents discarded.
  - prev_bit=0, state=IDLE, acc=0, step counter=0.
  - in_ready=1 once reset is applied.
- Tick detection:
  - prev_bit <= phase[sample_rate] every clock.
  - tick = phase[sample_rate] != prev_bit, so each edge of the selected bit counts, giving two ticks per bit period.
  - Changing sample_rate may produce one extra tick; this is defined behaviour.
- Push: occurs when in_valid && in_ready on a clock edge. Data is written at the tail and fifo_level increments.
- Pop: occurs when tick && level != 0. The head becomes target and fifo_level decrements.
- Push and pop in the same cycle: both happen, level is unchanged.
  - When full: in_ready=0, so no push that cycle, even if a pop occurs.
  - When empty: the pop fails with underflow, the push is stored, level becomes 1.
- Arithmetic:
  - diff = target - shaped, sign-extended to 17 bits.
  - acc is a (16+RAMP_LOG2)-bit signed value, loaded as shaped<<RAMP_LOG2 on pop.
  - Each RAMP clock: acc += diff (sign-extended), and shaped <= new acc >>> RAMP_LOG2.
  - After 2^RAMP_LOG2 steps acc equals target<<RAMP_LOG2 exactly, so shaped == target.
  - No intermediate overflow or wrap, including -32768 <-> 32767 transitions; the ramp is monotonic.
- State machine:
  - IDLE: shaped holds. On a successful pop: load acc and diff, clear the counter, go to RAMP.
  - RAMP: step once per clock and increment the counter. On the 2^RAMP_LOG2-th step, go to IDLE with shaped=target.
  - Tick during RAMP with FIFO non-empty: abandon the current ramp. The new start is the present shaped value; reload acc, diff and the counter; stay in RAMP.
  - Tick with FIFO empty, in any state: underflow=1 for that one clock. Any in-progress ramp continues undisturbed; in IDLE, shaped holds.
- Latency:
  - Tick sampled at edge T causes the pop at T.
  - First ramp step is visible on shaped after edge T+1.
  - shaped == target after edge T+2^RAMP_LOG2.
- underflow is registered and deasserts the clock after the tick.

Test Plan:
- Basic ramp (defaults): reset, push 0x4000, toggle phase[sample_rate] -> shaped = 0x0100 one clock after the pop, +0x0100 per clock, 0x4000 after 64 clocks, then holds in IDLE.
- Negative ramp: from shaped=0x4000, push 0xC000 and tick -> step -0x0200 per clock; shaped = 0xC000 exactly after 64 clocks, monotonic decrease.
- Full scale: shaped=0x7FFF, push 0x8000, tick -> monotonic descent with no sign wrap, final 0x8000; reverse transition ends at 0x7FFF.
- Empty FIFO: with fifo_level=0 and IDLE at shaped=0x1234, give a tick -> underflow high exactly one clock, shaped stays 0x1234.
- Full FIFO and re-trigger:
  - Push 16 samples -> in_ready=0, 17th in_valid held and not accepted.
  - One tick -> level 15, in_ready=1, held sample accepted next clock.
  - Tick again 10 clocks into a ramp -> new ramp starts from the current shaped value and reaches the new target 64 clocks later.
- Reset mid-ramp: assert rst_n=0 at clock 20 of a ramp -> shaped=0, fifo_level=0, in_ready=1 immediately (asynchronously); after release, a tick with empty FIFO -> underflow pulse.

Source files
------------

// File: rtl/ramp_shaper.sv
// Transmit amplitude shaper: buffers signed samples in a FIFO, releases one per
// NCO-derived tick, and ramps the output linearly toward each released sample.
module ramp_shaper #(
  parameter int DEPTH     = 16,
  parameter int RAMP_LOG2 = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              phase,
  input  logic [4:0]               sample_rate,
  input  logic [15:0]              in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [15:0]              shaped,
  output logic                     underflow,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW   = $clog2(DEPTH);
  localparam int LW   = AW + 1;
  localparam int ACCW = 16 + RAMP_LOG2;

  typedef enum logic {IDLE, RAMP} state_t;

  logic [15:0]              r_mem [DEPTH];
  logic [AW-1:0]            r_wr_ptr;
  logic [AW-1:0]            r_rd_ptr;
  logic [LW-1:0]            r_level;
  logic                     r_prev_bit;
  state_t                   r_state;
  state_t                   w_next_state;
  logic signed [ACCW-1:0]   r_acc;
  logic signed [16:0]       r_diff;
  logic [RAMP_LOG2-1:0]     r_cnt;
  logic [15:0]              r_shaped;
  logic                     r_underflow;

  logic                     w_bit;
  logic                     w_tick;
  logic                     w_full;
  logic                     w_empty;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_last;
  logic                     w_load;
  logic                     w_step;
  logic [15:0]              w_head;
  logic signed [16:0]       w_diff_new;
  logic signed [ACCW-1:0]   w_acc_load;
  logic signed [ACCW-1:0]   w_acc_sum;

  assign w_bit   = phase[sample_rate];
  assign w_tick  = w_bit ^ r_prev_bit;
  assign w_full  = (r_level == LW'(DEPTH));
  assign w_empty = (r_level == '0);
  assign w_push  = in_valid && !w_full;
  assign w_pop   = w_tick && !w_empty;
  assign w_last  = (r_cnt == '1);
  assign w_head  = r_mem[r_rd_ptr];

  // Both operands widened to 17 bits so full-scale swings cannot wrap.
  assign w_diff_new = $signed({w_head[15], w_head}) - $signed({r_shaped[15], r_shaped});
  assign w_acc_load = $signed({r_shaped, {RAMP_LOG2{1'b0}}});
  assign w_acc_sum  = r_acc + ACCW'(r_diff);

  assign in_ready   = !w_full;
  assign shaped     = r_shaped;
  assign underflow  = r_underflow;
  assign fifo_level = r_level;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_prev_bit  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_prev_bit  <= w_bit;
      r_underflow <= w_tick && w_empty;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_pop) w_next_state = RAMP;
      RAMP:    if (w_pop) w_next_state = RAMP;
               else if (w_last) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // A pop always reloads the ramp, so a re-trigger suppresses that cycle's step.
  always_comb begin
    w_load = 1'b0;
    w_step = 1'b0;
    case (r_state)
      IDLE:    w_load = w_pop;
      RAMP: begin
        w_load = w_pop;
        w_step = !w_pop;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_diff   <= '0;
      r_cnt    <= '0;
      r_shaped <= '0;
    end else if (w_load) begin
      r_acc  <= w_acc_load;
      r_diff <= w_diff_new;
      r_cnt  <= '0;
    end else if (w_step) begin
      r_acc    <= w_acc_sum;
      r_shaped <= w_acc_sum[ACCW-1:RAMP_LOG2];
      r_cnt    <= r_cnt + RAMP_LOG2'(1);
    end
  end

endmodule

// File: tb/tb_ramp_shaper.sv
// Scoreboard bench for ramp_shaper: a per-cycle reference model queues expected
// outputs at each rising edge; a monitor compares them on the falling edge.
module tb_ramp_shaper;

  localparam int DEPTH = 16;
  localparam int RL2   = 6;
  localparam int STEPS = 1 << RL2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] phase;
  logic [4:0]  sample_rate;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] shaped;
  logic        underflow;
  logic [4:0]  fifo_level;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int shaped;
    bit uf;
    int level;
  } exp_t;

  exp_t exp_q[$];
  bit   model_done = 1'b0;

  ramp_shaper #(.DEPTH(DEPTH), .RAMP_LOG2(RL2)) dut (
    .clk(clk), .rst_n(rst_n), .phase(phase), .sample_rate(sample_rate),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .shaped(shaped), .underflow(underflow), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: FIFO as a queue, ramp as start + floor((target-start)*k/2^RL2).
  initial begin
    int  fifo[$];
    int  m_shaped, m_start, m_target, m_k, m_level;
    bit  m_ramping, m_prev, m_uf, b, tick, push, pop;
    exp_t e;
    m_shaped = 0; m_start = 0; m_target = 0; m_k = 0;
    m_ramping = 0; m_prev = 0; m_uf = 0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        fifo.delete();
        m_shaped = 0; m_ramping = 0; m_prev = 0; m_uf = 0; m_k = 0;
      end else begin
        m_level = fifo.size();
        b     = phase[sample_rate];
        tick  = (b != m_prev);
        m_prev = b;
        push  = in_valid && (m_level < DEPTH);
        pop   = tick && (m_level != 0);
        m_uf  = tick && (m_level == 0);
        if (pop) begin
          m_start   = m_shaped;
          m_target  = fifo.pop_front();
          m_k       = 0;
          m_ramping = 1;
        end else if (m_ramping) begin
          m_k++;
          m_shaped = m_start + (((m_target - m_start) * m_k) >>> RL2);
          if (m_k == STEPS) m_ramping = 0;
        end
        if (push) fifo.push_back(int'($signed(in_data)));
      end
      e.shaped = m_shaped;
      e.uf     = m_uf;
      e.level  = fifo.size();
      exp_q.push_back(e);
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("shaped",    int'($signed(shaped)), e.shaped);
        check("underflow", int'(underflow),       int'(e.uf));
        check("level",     int'(fifo_level),      e.level);
        check("in_ready",  int'(in_ready),        int'(e.level != DEPTH));
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_tick();
    phase = phase ^ (32'd1 << sample_rate);
  endtask

  task automatic push_one(input logic [15:0] d);
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic ramp_to(input logic [15:0] d);
    push_one(d);
    do_tick();
    wait_cycles(STEPS + 6);
  endtask

  initial begin
    rst_n       = 1'b0;
    phase       = '0;
    sample_rate = 5'd3;
    in_data     = '0;
    in_valid    = 1'b0;
    #1;
    check("reset_shaped",   int'(shaped),     0);
    check("reset_level",    int'(fifo_level), 0);
    check("reset_in_ready", int'(in_ready),   1);
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(2);

    ramp_to(16'h4000);
    ramp_to(16'hC000);
    ramp_to(16'h7FFF);
    ramp_to(16'h8000);
    ramp_to(16'h7FFF);
    ramp_to(16'h1234);
    do_tick();
    wait_cycles(4);

    in_valid = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      in_data = 16'($urandom);
      @(negedge clk);
    end
    wait_cycles(3);
    do_tick();
    wait_cycles(2);
    in_valid = 1'b0;
    wait_cycles(10);
    do_tick();
    wait_cycles(STEPS + 6);

    for (int blk = 0; blk < 2; blk++) begin
      for (int c = 0; c < 1500; c++) begin
        in_valid = (blk == 0) ? ($urandom_range(2) == 0) : ($urandom_range(79) == 0);
        in_data  = 16'($urandom);
        if ($urandom_range(39) == 0) do_tick();
        if ($urandom_range(499) == 0) sample_rate = 5'($urandom_range(31));
        @(negedge clk);
      end
      in_valid = 1'b0;
    end
    sample_rate = 5'd3;
    wait_cycles(2 * STEPS * (DEPTH + 1));

    push_one(16'h2000);
    push_one(16'h5000);
    do_tick();
    wait_cycles(20);
    #1 rst_n = 1'b0;
    #1;
    check("async_shaped",   int'(shaped),     0);
    check("async_level",    int'(fifo_level), 0);
    check("async_in_ready", int'(in_ready),   1);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cycles(3);
    do_tick();
    wait_cycles(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
